// File: rtl/fifo_access_ctrl.sv
// Shares a lagging-flag character FIFO between NREQ round-robin writers and one
// valid/ready consumer, keeping its own authoritative occupancy count.
module fifo_access_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned NREQ  = 2,
  localparam int unsigned LW   = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    fifo_rst_n,
  output logic                    fifo_key_valid,
  output logic                    fifo_wr_en,
  output logic [WIDTH-1:0]        fifo_din,
  output logic                    fifo_rd_en,
  input  logic [WIDTH-1:0]        fifo_dout,
  input  logic                    fifo_full,
  input  logic                    fifo_empty,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  input  logic                    out_ready,
  output logic [LW-1:0]           level
);

  localparam int unsigned RW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {OpWr, OpRd} op_e;

  logic [LW-1:0]    level_q, level_d;
  logic [RW-1:0]    rr_last_q, rr_last_d;
  op_e              last_op_q, last_op_d;
  logic             rd_pend_q, rd_pend_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             en_q;

  logic             grant_found;
  logic [RW-1:0]    grant_idx;
  logic             wr_ok, rd_ok;
  logic             issue_wr, issue_rd;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q     <= '0;
      rr_last_q   <= RW'(NREQ - 1);
      last_op_q   <= OpRd;
      rd_pend_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      en_q        <= 1'b0;
    end else begin
      level_q     <= level_d;
      rr_last_q   <= rr_last_d;
      last_op_q   <= last_op_d;
      rd_pend_q   <= rd_pend_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      en_q        <= 1'b1;
    end
  end

  // Round-robin search starting just after the last granted requester
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      logic [RW-1:0] cand;
      cand = RW'((int'(rr_last_q) + k) % NREQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // FIFO flags may only veto an operation; level alone decides eligibility.
  always_comb begin
    wr_ok    = en_q && (level_q < LW'(DEPTH)) && !fifo_full && grant_found;
    rd_ok    = en_q && (level_q != '0) && !fifo_empty && !out_valid_q && !rd_pend_q;
    issue_wr = wr_ok && (!rd_ok || (last_op_q == OpRd));
    issue_rd = rd_ok && (!wr_ok || (last_op_q == OpWr));
  end

  // Next state
  always_comb begin
    level_d     = level_q;
    rr_last_d   = rr_last_q;
    last_op_d   = last_op_q;
    rd_pend_d   = issue_rd;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (issue_wr) begin
      level_d   = level_q + LW'(1);
      rr_last_d = grant_idx;
      last_op_d = OpWr;
    end else if (issue_rd) begin
      level_d   = level_q - LW'(1);
      last_op_d = OpRd;
    end
    // rd_pend and out_valid are mutually exclusive, so load never meets a handshake
    if (rd_pend_q) begin
      out_valid_d = 1'b1;
      out_data_d  = fifo_dout;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Outputs
  always_comb begin
    req_ready      = issue_wr ? (NREQ'(1) << grant_idx) : '0;
    fifo_din       = issue_wr ? req_data[grant_idx*WIDTH +: WIDTH] : '0;
    fifo_wr_en     = issue_wr;
    fifo_rd_en     = issue_rd;
    fifo_rst_n     = ~rst;
    fifo_key_valid = en_q;
    out_valid      = out_valid_q;
    out_data       = out_data_q;
    level          = level_q;
  end

endmodule

// File: tb/tb_fifo_access_ctrl.sv
// Directed bench for fifo_access_ctrl with a behavioural FIFO whose flags lag by two cycles.
module tb_fifo_access_ctrl;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int NREQ  = 2;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  fifo_rst_n, fifo_key_valid, fifo_wr_en, fifo_rd_en;
  logic [WIDTH-1:0]      fifo_din;
  logic [WIDTH-1:0]      fifo_dout;
  logic                  fifo_full, fifo_empty;
  logic                  out_valid, out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [LW-1:0]         level;

  fifo_access_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .fifo_rst_n     (fifo_rst_n),
    .fifo_key_valid (fifo_key_valid),
    .fifo_wr_en     (fifo_wr_en),
    .fifo_din       (fifo_din),
    .fifo_rd_en     (fifo_rd_en),
    .fifo_dout      (fifo_dout),
    .fifo_full      (fifo_full),
    .fifo_empty     (fifo_empty),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_ready      (out_ready),
    .level          (level)
  );

  always #5 clk = ~clk;

  // FIFO model: flags derived from the post-edge count, then delayed one more stage
  logic [WIDTH-1:0] mem [DEPTH];
  int               cnt, wp, rp, cnt_n;
  logic             e1, f1;
  always @(posedge clk) begin
    if (!fifo_rst_n) begin
      cnt <= 0; wp <= 0; rp <= 0; fifo_dout <= '0;
      e1 <= 1'b1; fifo_empty <= 1'b1; f1 <= 1'b0; fifo_full <= 1'b0;
    end else begin
      cnt_n = cnt;
      if (fifo_wr_en && cnt < DEPTH) begin
        mem[wp] <= fifo_din; wp <= (wp + 1) % DEPTH; cnt_n = cnt_n + 1;
      end
      if (fifo_rd_en && cnt > 0) begin
        fifo_dout <= mem[rp]; rp <= (rp + 1) % DEPTH; cnt_n = cnt_n - 1;
      end
      cnt <= cnt_n;
      e1 <= (cnt_n == 0); fifo_empty <= e1;
      f1 <= (cnt_n == DEPTH); fifo_full <= f1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [WIDTH-1:0] q[$];
  int  n0, n1, exp_g, wr_cnt, rd_cnt, got, age, n;
  logic prev_v;

  initial begin
    rst = 1'b1; req_valid = 2'b11; req_data = {8'h20, 8'h10}; out_ready = 1'b0;

    // Reset held three cycles with both requesters asking
    repeat (3) begin
      tick();
      check("rst_ready", req_ready, 0);
      check("rst_wr", fifo_wr_en, 0);
      check("rst_rd", fifo_rd_en, 0);
      check("rst_din", fifo_din, 0);
      check("rst_keyv", fifo_key_valid, 0);
      check("rst_fifo_rst_n", fifo_rst_n, 0);
      check("rst_ovalid", out_valid, 0);
      check("rst_odata", out_data, 0);
      check("rst_level", level, 0);
    end
    rst = 1'b0;
    #1;
    check("rel_fifo_rst_n", fifo_rst_n, 1);
    check("rel_keyv", fifo_key_valid, 0);
    check("rel_ready", req_ready, 0);
    check("rel_wr", fifo_wr_en, 0);

    // Round-robin fill until level reaches DEPTH, consumer stalled
    n0 = 0; n1 = 0; exp_g = 0; wr_cnt = 0; rd_cnt = 0;
    for (int c = 0; c < 24; c++) begin
      tick();
      req_data = {8'(8'h20 + n1), 8'(8'h10 + n0)};
      #1;
      check("rr_excl", fifo_wr_en & fifo_rd_en, 0);
      if (c == 0) check("rr_first_keyv", fifo_key_valid, 1);
      if (fifo_wr_en) begin
        check("rr_grant", req_ready, (exp_g == 0) ? 1 : 2);
        check("rr_din", fifo_din, (exp_g == 0) ? 8'h10 + n0 : 8'h20 + n1);
        q.push_back((exp_g == 0) ? 8'(8'h10 + n0) : 8'(8'h20 + n1));
        if (exp_g == 0) n0++; else n1++;
        exp_g ^= 1;
        wr_cnt++;
      end
      if (fifo_rd_en) rd_cnt++;
      if (level == LW'(DEPTH)) check("full_nogrant", req_ready, 0);
    end
    check("rr_level", level, DEPTH);
    check("rr_wr_cnt", wr_cnt, 17);
    check("rr_rd_cnt", rd_cnt, 1);
    check("rr_ovalid", out_valid, 1);
    check("rr_odata", out_data, 8'h10);

    // Backpressure: output must hold and no read may issue
    req_valid = 2'b00;
    void'(q.pop_front());
    for (int c = 0; c < 10; c++) begin
      tick();
      check("bp_ovalid", out_valid, 1);
      check("bp_odata", out_data, 8'h10);
      check("bp_rd", fifo_rd_en, 0);
    end
    tick(); out_ready = 1'b1; #1;
    tick();
    check("bp_clear", out_valid, 0);
    check("bp_rd_after", fifo_rd_en, 1);
    tick();
    check("bp_rd_pend", fifo_rd_en, 0);
    tick();
    check("bp_ovalid2", out_valid, 1);

    // Drain the remaining 16 words in write order, checking read latency
    got = 0; age = 2; prev_v = 1'b1;
    for (int c = 0; c < 80 && got < 16; c++) begin
      age++;
      if (out_valid && !prev_v) check("drain_lat", age, 2);
      if (out_valid) begin
        if (q.size() == 0) check("drain_spurious", 1, 0);
        else check("drain_data", out_data, q.pop_front());
        got++;
      end
      check("drain_excl", fifo_wr_en & fifo_rd_en, 0);
      if (fifo_rd_en) age = 0;
      prev_v = out_valid;
      tick();
    end
    check("drain_got", got, 16);
    repeat (4) tick();
    check("drain_level", level, 0);
    check("drain_ovalid", out_valid, 0);

    // Single word: write at t, read at t+2, output at t+4
    req_valid = 2'b01; req_data = {8'h00, 8'hA5}; #1;
    check("sw_wr", fifo_wr_en, 1);
    check("sw_ready", req_ready, 1);
    check("sw_din", fifo_din, 8'hA5);
    tick(); req_valid = 2'b00; #1;
    check("sw_level1", level, 1);
    check("sw_no_early_rd", fifo_rd_en, 0);
    tick();
    check("sw_rd", fifo_rd_en, 1);
    tick();
    check("sw_rd_once", fifo_rd_en, 0);
    check("sw_ovalid_early", out_valid, 0);
    tick();
    check("sw_ovalid", out_valid, 1);
    check("sw_odata", out_data, 8'hA5);
    check("sw_level0", level, 0);
    tick();
    check("sw_clear", out_valid, 0);
    check("sw_no_rd", fifo_rd_en, 0);

    // Contention: requester 1 always valid, consumer always ready
    req_valid = 2'b10; n = 0; got = 0; rd_cnt = 0; wr_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      req_data = {8'(8'h40 + n), 8'h00};
      #1;
      check("ct_excl", fifo_wr_en & fifo_rd_en, 0);
      if (fifo_wr_en) begin
        check("ct_grant", req_ready, 2);
        q.push_back(8'(8'h40 + n));
        n++; wr_cnt++;
      end
      if (fifo_rd_en) rd_cnt++;
      if (out_valid) begin
        if (q.size() == 0) check("ct_spurious", 1, 0);
        else check("ct_data", out_data, q.pop_front());
        got++;
      end
      tick();
    end
    check("ct_interleave", (rd_cnt > 0) && (wr_cnt > rd_cnt), 1);
    req_valid = 2'b00;
    for (int c = 0; c < 100 && q.size() != 0; c++) begin
      #1;
      if (out_valid) begin
        check("ct_tail_data", out_data, q.pop_front());
        got++;
      end
      tick();
    end
    check("ct_all_out", got, wr_cnt);
    repeat (3) tick();
    check("ct_level", level, 0);

    // Reset in the cycle after a read strobe drops the read
    req_valid = 2'b01; req_data = {8'h00, 8'h77}; #1;
    check("mr_wr", fifo_wr_en, 1);
    tick(); req_valid = 2'b00;
    for (int c = 0; c < 10 && !fifo_rd_en; c++) tick();
    check("mr_rd_seen", fifo_rd_en, 1);
    tick(); rst = 1'b1; #1;
    check("mr_fifo_rst_n", fifo_rst_n, 0);
    check("mr_ovalid0", out_valid, 0);
    tick();
    check("mr_ovalid1", out_valid, 0);
    check("mr_level", level, 0);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("mr_quiet", out_valid, 0);
    end
    req_valid = 2'b01; req_data = {8'h00, 8'h55}; #1;
    check("mr_resume_wr", fifo_wr_en, 1);
    check("mr_resume_ready", req_ready, 1);
    tick(); req_valid = 2'b00;
    for (int c = 0; c < 10 && !out_valid; c++) tick();
    check("mr_resume_ovalid", out_valid, 1);
    check("mr_resume_data", out_data, 8'h55);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
